// File: rtl/taxi_eth_mac_pause_rx_timer.sv
// Receive-side 802.3 annex 31B PAUSE responder: runs the pause timer in
// 512-bit-time quanta and drives a four-phase req/ack halt request into the TX MAC.
module taxi_eth_mac_pause_rx_timer #(
    parameter int DATA_W   = 8,
    parameter int QUANTA_W = 16,
    parameter int PRESCALE = 512 / DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clk_en,
    input  logic                cfg_en,
    input  logic                rx_lfc_valid,
    input  logic [QUANTA_W-1:0] rx_lfc_quanta,
    output logic                tx_pause_req,
    input  logic                tx_pause_ack,
    output logic [QUANTA_W-1:0] quanta_remaining,
    output logic                stat_rx_lfc_pkt,
    output logic                stat_rx_lfc_xon,
    output logic                stat_rx_lfc_xoff,
    output logic                stat_rx_lfc_paused
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_RELOAD = PS_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAUSE,
        ST_PAUSED,
        ST_RELEASE
    } state_t;

    state_t              state_q, state_d;
    logic [QUANTA_W-1:0] count_q, count_d;
    logic [PS_W-1:0]     presc_q, presc_d;
    logic                req_q, req_d;
    logic                pkt_q, pkt_d;
    logic                xon_q, xon_d;
    logic                xoff_q, xoff_d;
    logic                paused_q, paused_d;
    logic                accept;

    assign accept = rx_lfc_valid && cfg_en;

    // Timer: a new frame replaces the count outright; disabling LFC clears it.
    always_comb begin
        count_d = count_q;
        presc_d = presc_q;
        if (!cfg_en) begin
            count_d = '0;
            presc_d = PS_RELOAD;
        end else if (accept) begin
            count_d = rx_lfc_quanta;
            presc_d = PS_RELOAD;
        end else if (clk_en && count_q != '0) begin
            if (presc_q == '0) begin
                count_d = count_q - QUANTA_W'(1);
                presc_d = PS_RELOAD;
            end else begin
                presc_d = presc_q - PS_W'(1);
            end
        end
    end

    // Handshake FSM keyed on the next count, so a load in the expiry cycle keeps the pause.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (count_d != '0) begin
                    state_d = tx_pause_ack ? ST_RELEASE : ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (count_d == '0) begin
                    state_d = ST_RELEASE;
                end else if (tx_pause_ack) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (count_d == '0) begin
                    state_d = ST_RELEASE;
                end else if (!tx_pause_ack) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_RELEASE: begin
                if (!tx_pause_ack) begin
                    state_d = (count_d != '0) ? ST_PAUSE : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_d    = (state_d == ST_PAUSE) || (state_d == ST_PAUSED);
        pkt_d    = accept;
        xon_d    = accept && (rx_lfc_quanta == '0);
        xoff_d   = accept && (rx_lfc_quanta != '0);
        paused_d = (state_q == ST_PAUSED) && clk_en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            presc_q  <= PS_RELOAD;
            req_q    <= 1'b0;
            pkt_q    <= 1'b0;
            xon_q    <= 1'b0;
            xoff_q   <= 1'b0;
            paused_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            presc_q  <= presc_d;
            req_q    <= req_d;
            pkt_q    <= pkt_d;
            xon_q    <= xon_d;
            xoff_q   <= xoff_d;
            paused_q <= paused_d;
        end
    end

    assign tx_pause_req       = req_q;
    assign quanta_remaining   = count_q;
    assign stat_rx_lfc_pkt    = pkt_q;
    assign stat_rx_lfc_xon    = xon_q;
    assign stat_rx_lfc_xoff   = xoff_q;
    assign stat_rx_lfc_paused = paused_q;

endmodule

// File: tb/tb_taxi_eth_mac_pause_rx_timer.sv
// Bench for the PAUSE receive timer: directed scenarios plus a stat-pulse scoreboard.
module tb_taxi_eth_mac_pause_rx_timer;

    localparam int DATA_W   = 8;
    localparam int QUANTA_W = 16;
    localparam int ACK_DLY  = 3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                clk_en = 1'b0;
    logic                cfg_en = 1'b0;
    logic                rx_lfc_valid = 1'b0;
    logic [QUANTA_W-1:0] rx_lfc_quanta = '0;
    logic                tx_pause_ack = 1'b0;
    logic                tx_pause_req;
    logic [QUANTA_W-1:0] quanta_remaining;
    logic                stat_rx_lfc_pkt;
    logic                stat_rx_lfc_xon;
    logic                stat_rx_lfc_xoff;
    logic                stat_rx_lfc_paused;

    taxi_eth_mac_pause_rx_timer #(
        .DATA_W  (DATA_W),
        .QUANTA_W(QUANTA_W)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .clk_en            (clk_en),
        .cfg_en            (cfg_en),
        .rx_lfc_valid      (rx_lfc_valid),
        .rx_lfc_quanta     (rx_lfc_quanta),
        .tx_pause_req      (tx_pause_req),
        .tx_pause_ack      (tx_pause_ack),
        .quanta_remaining  (quanta_remaining),
        .stat_rx_lfc_pkt   (stat_rx_lfc_pkt),
        .stat_rx_lfc_xon   (stat_rx_lfc_xon),
        .stat_rx_lfc_xoff  (stat_rx_lfc_xoff),
        .stat_rx_lfc_paused(stat_rx_lfc_paused)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic xon;
        logic xoff;
        int   cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   paused_cnt = 0;
    int   en_mode = 0;
    bit   ack_auto = 1'b1;
    logic [ACK_DLY-1:0] hist = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Stat pulses are scored against frames pushed when they were driven.
    always @(negedge clk) begin
        if (stat_rx_lfc_paused) paused_cnt++;
        if (stat_rx_lfc_pkt) begin
            if (sb.size() == 0) begin
                check_eq("stat_unexpected", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("stat_xon", int'(stat_rx_lfc_xon), int'(mon_e.xon));
                check_eq("stat_xoff", int'(stat_rx_lfc_xoff), int'(mon_e.xoff));
                check_eq("stat_latency", cyc - mon_e.cyc, 1);
            end
        end else if (stat_rx_lfc_xon || stat_rx_lfc_xoff) begin
            check_eq("stat_orphan", 1, 0);
        end
    end

    // Beat-enable generator: 0 = every cycle, 1 = one in ten, other = never.
    initial begin
        int c = 0;
        forever begin
            @(posedge clk);
            #1;
            case (en_mode)
                0: clk_en = 1'b1;
                1: begin
                    clk_en = (c == 0);
                    c = (c == 9) ? 0 : c + 1;
                end
                default: clk_en = 1'b0;
            endcase
        end
    end

    // TX MAC model: ack follows req with a fixed lag when in automatic mode.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            hist = {hist[ACK_DLY-2:0], tx_pause_req};
            if (ack_auto) tx_pause_ack = hist[ACK_DLY-1];
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [QUANTA_W-1:0] q);
        exp_t e;
        rx_lfc_valid  = 1'b1;
        rx_lfc_quanta = q;
        if (cfg_en) begin
            e.xon  = (q == '0);
            e.xoff = (q != '0);
            e.cyc  = cyc;
            sb.push_back(e);
        end
        tick(1);
        rx_lfc_valid = 1'b0;
    endtask

    task automatic run_to_zero(input string tag, input int budget, output int n);
        n = 0;
        while (quanta_remaining != '0 && n < budget) begin
            tick(1);
            n++;
        end
        if (quanta_remaining != '0) check_eq({tag, "_timeout"}, int'(quanta_remaining), 0);
    endtask

    task automatic wait_qr(input string tag, input int val, input int budget);
        int n = 0;
        while (int'(quanta_remaining) != val && n < budget) begin
            tick(1);
            n++;
        end
        if (int'(quanta_remaining) != val) check_eq({tag, "_timeout"}, int'(quanta_remaining), val);
    endtask

    initial begin
        int n;
        bit seen;
        en_mode = 0;
        cfg_en  = 1'b1;
        rst_n   = 1'b0;
        tick(3);
        check_eq("rst_req", int'(tx_pause_req), 0);
        check_eq("rst_qr", int'(quanta_remaining), 0);
        check_eq("rst_pkt", int'(stat_rx_lfc_pkt), 0);
        check_eq("rst_xon", int'(stat_rx_lfc_xon), 0);
        check_eq("rst_xoff", int'(stat_rx_lfc_xoff), 0);
        check_eq("rst_paused", int'(stat_rx_lfc_paused), 0);
        rst_n = 1'b1;
        tick(100);
        check_eq("idle_req", int'(tx_pause_req), 0);
        check_eq("idle_qr", int'(quanta_remaining), 0);
        check_eq("idle_paused", int'(stat_rx_lfc_paused), 0);

        // XOFF of 2 quanta: 128 beats of link time, ack lags req by ACK_DLY cycles.
        paused_cnt = 0;
        send(16'd2);
        check_eq("q2_req", int'(tx_pause_req), 1);
        check_eq("q2_qr", int'(quanta_remaining), 2);
        run_to_zero("q2", 300, n);
        check_eq("q2_beats", n, 128);
        check_eq("q2_req_drop", int'(tx_pause_req), 0);
        tick(10);
        check_eq("q2_paused_cnt", paused_cnt, 128 - ACK_DLY);
        check_eq("q2_req_idle", int'(tx_pause_req), 0);

        // XON part way through a pause.
        send(16'd10);
        tick(100);
        check_eq("xon_qr_before", int'(quanta_remaining), 9);
        send(16'd0);
        check_eq("xon_req", int'(tx_pause_req), 0);
        check_eq("xon_qr", int'(quanta_remaining), 0);
        tick(10);
        check_eq("xon_req_idle", int'(tx_pause_req), 0);

        // Load coinciding with expiry, then reload at count 1 restarting the prescaler.
        send(16'd5);
        wait_qr("q5", 1, 400);
        tick(63);
        send(16'd3);
        check_eq("coll_qr", int'(quanta_remaining), 3);
        check_eq("coll_req", int'(tx_pause_req), 1);
        wait_qr("q3", 1, 300);
        send(16'd2);
        check_eq("reload_qr", int'(quanta_remaining), 2);
        check_eq("reload_req", int'(tx_pause_req), 1);
        run_to_zero("reload", 300, n);
        check_eq("reload_beats", n, 128);
        tick(10);

        // Maximum quanta counts down without wrapping.
        send(16'hFFFF);
        check_eq("max_qr", int'(quanta_remaining), 65535);
        tick(64);
        check_eq("max_qr_dec", int'(quanta_remaining), 65534);
        send(16'd0);
        tick(10);

        // No beat enables: the timer must hold.
        en_mode = 2;
        tick(2);
        paused_cnt = 0;
        send(16'd1);
        tick(200);
        check_eq("frz_qr", int'(quanta_remaining), 1);
        check_eq("frz_req", int'(tx_pause_req), 1);
        check_eq("frz_paused_cnt", paused_cnt, 0);
        send(16'd0);
        tick(10);
        check_eq("frz_req_idle", int'(tx_pause_req), 0);

        // One beat in ten: a single quantum takes about 640 cycles.
        en_mode = 1;
        send(16'd1);
        run_to_zero("slow", 2000, n);
        check_eq("slow_lo", int'(n >= 630), 1);
        check_eq("slow_hi", int'(n <= 650), 1);
        en_mode = 0;
        tick(10);

        // Re-pause while ack is still high: req must wait for ack to fall.
        ack_auto     = 1'b0;
        tx_pause_ack = 1'b0;
        send(16'd4);
        check_eq("rp_req", int'(tx_pause_req), 1);
        tx_pause_ack = 1'b1;
        tick(2);
        send(16'd0);
        check_eq("rp_rel_req", int'(tx_pause_req), 0);
        send(16'd7);
        check_eq("rp_qr", int'(quanta_remaining), 7);
        seen = 1'b0;
        repeat (20) begin
            tick(1);
            if (tx_pause_req) seen = 1'b1;
        end
        check_eq("rp_req_while_ack", int'(seen), 0);
        tx_pause_ack = 1'b0;
        tick(1);
        check_eq("rp_req_rise", int'(tx_pause_req), 1);

        // Disabling LFC mid-pause releases and then ignores frames.
        tx_pause_ack = 1'b1;
        tick(2);
        cfg_en = 1'b0;
        tick(1);
        check_eq("dis_req", int'(tx_pause_req), 0);
        check_eq("dis_qr", int'(quanta_remaining), 0);
        send(16'd9);
        tick(5);
        check_eq("dis_ign_req", int'(tx_pause_req), 0);
        check_eq("dis_ign_qr", int'(quanta_remaining), 0);
        tx_pause_ack = 1'b0;
        tick(3);
        cfg_en   = 1'b1;
        ack_auto = 1'b1;
        tick(5);

        // Asynchronous reset drops req without waiting for a clock.
        send(16'd5);
        tick(5);
        check_eq("ar_req", int'(tx_pause_req), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_req_async", int'(tx_pause_req), 0);
        check_eq("ar_qr_async", int'(quanta_remaining), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(5);
        check_eq("ar_req_after", int'(tx_pause_req), 0);

        check_eq("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
